// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage sitting between the PC register and decode in the
// non-forwarding pipeline. It computes the next PC, drives the PC register's
// active-low load enable, and issues addresses to a synchronous-read
// instruction memory.
//
// The memory returns data one edge after the address is sampled. The
// in-flight tracker remembers which PC that response belongs to. A one-entry
// skid buffer parks the response when a stall arrives while it is in flight.
// The stage also owns the IF/ID register: stall holds it, flush invalidates
// it, and an empty cycle inserts a counted bubble.
//
// Ports
//   clk_i          clock
//   rst_i          asynchronous active-high reset
//   pc_i           current PC from the PC register
//   next_pc_o      next PC to the PC register
//   pc_enable_no   active-low PC load enable (0 = load next_pc_o)
//   imem_addr_o    instruction memory address (always pc_i)
//   imem_rd_o      read strobe, high when a fetch is issued
//   imem_rdata_i   memory data for the address sampled at the previous edge
//   stall_i        hazard stall: hold PC and IF/ID
//   flush_i        taken branch/jump redirect from EX
//   redirect_pc_i  redirect target (low two bits ignored)
//   if_id_valid_o  IF/ID holds a valid instruction
//   if_id_pc_o     PC of the IF/ID instruction
//   if_id_instr_o  IF/ID instruction
//   bubble_cnt_o   saturating count of bubbles inserted into IF/ID
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int WIDTH   = 32,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [WIDTH-1:0]   pc_i,
    output logic [WIDTH-1:0]   next_pc_o,
    output logic               pc_enable_no,
    output logic [WIDTH-1:0]   imem_addr_o,
    output logic               imem_rd_o,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic [WIDTH-1:0]   redirect_pc_i,
    output logic               if_id_valid_o,
    output logic [WIDTH-1:0]   if_id_pc_o,
    output logic [INSTR_W-1:0] if_id_instr_o,
    output logic [CNT_W-1:0]   bubble_cnt_o
);

    logic               issue;
    logic               bubble_evt;
    logic [WIDTH-1:0]   pc_plus4;
    logic [WIDTH-1:0]   redirect_aligned;

    logic               inflight_valid;
    logic [WIDTH-1:0]   inflight_pc;

    logic               skid_valid;
    logic [WIDTH-1:0]   skid_pc;
    logic [INSTR_W-1:0] skid_instr;

    logic               if_id_valid;
    logic [WIDTH-1:0]   if_id_pc;
    logic [INSTR_W-1:0] if_id_instr;
    logic [CNT_W-1:0]   bubble_cnt;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Combinational fetch control
    // ------------------------------------------------------------------
    assign issue            = !rst_i && !stall_i && !flush_i;
    assign pc_plus4         = pc_i + WIDTH'(4);
    // Masking rather than slicing keeps every redirect bit in use.
    assign redirect_aligned = redirect_pc_i & ~WIDTH'(3);

    assign next_pc_o   = flush_i ? redirect_aligned : pc_plus4;
    assign imem_addr_o = pc_i;
    assign imem_rd_o   = issue;

    // Reset gates the enable so a flush during reset cannot move the PC.
    assign pc_enable_no = rst_i || !(flush_i || issue);

    // A bubble is any edge where IF/ID ends up empty through no stall:
    // every flush edge, and a normal edge with nothing to deliver.
    assign bubble_evt = !rst_i &&
                        (flush_i || (!stall_i && !skid_valid && !inflight_valid));

    // ------------------------------------------------------------------
    // In-flight tracker, skid buffer and IF/ID register
    // Priority: flush > stall > normal.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight_valid <= 1'b0;
            inflight_pc    <= '0;
            skid_valid     <= 1'b0;
            skid_pc        <= '0;
            skid_instr     <= '0;
            if_id_valid    <= 1'b0;
            if_id_pc       <= '0;
            if_id_instr    <= '0;
        end else if (flush_i) begin
            // The response arriving this cycle belongs to the wrong path.
            inflight_valid <= 1'b0;
            skid_valid     <= 1'b0;
            if_id_valid    <= 1'b0;
        end else if (stall_i) begin
            // Park the response now, since memory will not repeat it.
            if (inflight_valid) begin
                skid_valid <= 1'b1;
                skid_pc    <= inflight_pc;
                skid_instr <= imem_rdata_i;
            end
            inflight_valid <= 1'b0;
        end else begin
            if (skid_valid) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= skid_pc;
                if_id_instr <= skid_instr;
                skid_valid  <= 1'b0;
            end else if (inflight_valid) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= inflight_pc;
                if_id_instr <= imem_rdata_i;
            end else begin
                // Bubble: pc/instr keep their old contents.
                if_id_valid <= 1'b0;
            end
            inflight_valid <= 1'b1;
            inflight_pc    <= pc_i;
        end
    end

    // ------------------------------------------------------------------
    // Saturating bubble counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bubble_cnt <= '0;
        end else if (bubble_evt && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    assign if_id_valid_o = if_id_valid;
    assign if_id_pc_o    = if_id_pc;
    assign if_id_instr_o = if_id_instr;
    assign bubble_cnt_o  = bubble_cnt;

    // The skid only fills from an in-flight response and clears the
    // in-flight flag in the same edge, so one entry is always enough.
    a_skid_depth1 : assert property (@(posedge clk_i) disable iff (rst_i)
                                     !(skid_valid && inflight_valid));

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam int CNT_W = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [31:0]       pc_i;
    logic [31:0]       next_pc_o;
    logic              pc_enable_no;
    logic [31:0]       imem_addr_o;
    logic              imem_rd_o;
    logic [31:0]       imem_rdata_i;
    logic              stall_i;
    logic              flush_i;
    logic [31:0]       redirect_pc_i;
    logic              if_id_valid_o;
    logic [31:0]       if_id_pc_o;
    logic [31:0]       if_id_instr_o;
    logic [CNT_W-1:0]  bubble_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    fetch_stage #(.WIDTH(32), .INSTR_W(32), .CNT_W(CNT_W)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .pc_i          (pc_i),
        .next_pc_o     (next_pc_o),
        .pc_enable_no  (pc_enable_no),
        .imem_addr_o   (imem_addr_o),
        .imem_rd_o     (imem_rd_o),
        .imem_rdata_i  (imem_rdata_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_pc_i (redirect_pc_i),
        .if_id_valid_o (if_id_valid_o),
        .if_id_pc_o    (if_id_pc_o),
        .if_id_instr_o (if_id_instr_o),
        .bubble_cnt_o  (bubble_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // PC register environment model.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pc_i <= 32'h0;
        else if (!pc_enable_no) pc_i <= next_pc_o;
    end

    // Synchronous-read memory: word i holds 0x1000_0000 + i.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    always @(posedge clk_i) imem_rdata_i <= mem_word(imem_addr_o);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        flush;
        logic [31:0] redir;
        logic [31:0] exp_next;
        logic        exp_en_n;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [3:0]  exp_bub;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic f, input logic [31:0] r,
                                input logic [31:0] nx, input logic en,
                                input logic v, input logic [31:0] p,
                                input logic [31:0] ins, input logic [3:0] b);
        vec_t t;
        t.stall = s; t.flush = f; t.redir = r; t.exp_next = nx; t.exp_en_n = en;
        t.exp_valid = v; t.exp_pc = p; t.exp_instr = ins; t.exp_bub = b;
        return t;
    endfunction

    vec_t tbl [21];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset release from pc 0, then a 3-cycle stall at PC 0x10 with 0x0C in flight.
        tbl[0]  = mk(0, 0, 32'h0,        32'h4,        0, 0, 32'h0,        32'h0,        1);
        tbl[1]  = mk(0, 0, 32'h0,        32'h8,        0, 1, 32'h0,        32'h10000000, 1);
        tbl[2]  = mk(0, 0, 32'h0,        32'hC,        0, 1, 32'h4,        32'h10000001, 1);
        tbl[3]  = mk(0, 0, 32'h0,        32'h10,       0, 1, 32'h8,        32'h10000002, 1);
        tbl[4]  = mk(1, 0, 32'h0,        32'h14,       1, 1, 32'h8,        32'h10000002, 1);
        tbl[5]  = mk(1, 0, 32'h0,        32'h14,       1, 1, 32'h8,        32'h10000002, 1);
        tbl[6]  = mk(1, 0, 32'h0,        32'h14,       1, 1, 32'h8,        32'h10000002, 1);
        tbl[7]  = mk(0, 0, 32'h0,        32'h14,       0, 1, 32'hC,        32'h10000003, 1);
        tbl[8]  = mk(0, 0, 32'h0,        32'h18,       0, 1, 32'h10,       32'h10000004, 1);
        tbl[9]  = mk(0, 0, 32'h0,        32'h1C,       0, 1, 32'h14,       32'h10000005, 1);
        tbl[10] = mk(0, 0, 32'h0,        32'h20,       0, 1, 32'h18,       32'h10000006, 1);
        // Flush to 0x103 at PC 0x20: one dead cycle, then (0x100, mem[0x40]).
        tbl[11] = mk(0, 1, 32'h103,      32'h100,      0, 0, 32'h0,        32'h0,        2);
        tbl[12] = mk(0, 0, 32'h0,        32'h104,      0, 0, 32'h0,        32'h0,        3);
        tbl[13] = mk(0, 0, 32'h0,        32'h108,      0, 1, 32'h100,      32'h10000040, 3);
        // Fill the skid, then flush and stall together: flush wins, skid dropped.
        tbl[14] = mk(1, 0, 32'h0,        32'h10C,      1, 1, 32'h100,      32'h10000040, 3);
        tbl[15] = mk(1, 1, 32'h200,      32'h200,      0, 0, 32'h0,        32'h0,        4);
        tbl[16] = mk(0, 0, 32'h0,        32'h204,      0, 0, 32'h0,        32'h0,        5);
        tbl[17] = mk(0, 0, 32'h0,        32'h208,      0, 1, 32'h200,      32'h10000080, 5);
        // Redirect to the top word and wrap to 0.
        tbl[18] = mk(0, 1, 32'hFFFFFFFF, 32'hFFFFFFFC, 0, 0, 32'h0,        32'h0,        6);
        tbl[19] = mk(0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        7);
        tbl[20] = mk(0, 0, 32'h0,        32'h4,        0, 1, 32'hFFFFFFFC, 32'h4FFFFFFF, 7);

        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; redirect_pc_i = 32'h0;
        @(negedge clk_i); @(negedge clk_i);
        chk("rst valid",  {31'b0, if_id_valid_o}, 32'h0);
        chk("rst pc",     if_id_pc_o,             32'h0);
        chk("rst instr",  if_id_instr_o,          32'h0);
        chk("rst bubble", {28'b0, bubble_cnt_o},  32'h0);
        chk("rst en_n",   {31'b0, pc_enable_no},  32'h1);
        chk("rst rd",     {31'b0, imem_rd_o},     32'h0);
        flush_i = 1'b1; redirect_pc_i = 32'h40;
        #1;
        chk("rst flush en_n", {31'b0, pc_enable_no}, 32'h1);
        chk("rst flush rd",   {31'b0, imem_rd_o},    32'h0);
        flush_i = 1'b0; redirect_pc_i = 32'h0;
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 21; i++) begin
            stall_i = tbl[i].stall; flush_i = tbl[i].flush; redirect_pc_i = tbl[i].redir;
            #1;
            chk($sformatf("row%0d next_pc", i), next_pc_o, tbl[i].exp_next);
            chk($sformatf("row%0d en_n", i), {31'b0, pc_enable_no}, {31'b0, tbl[i].exp_en_n});
            chk($sformatf("row%0d rd", i), {31'b0, imem_rd_o},
                {31'b0, !(tbl[i].stall || tbl[i].flush)});
            @(posedge clk_i); #1;
            chk($sformatf("row%0d valid", i), {31'b0, if_id_valid_o}, {31'b0, tbl[i].exp_valid});
            if (tbl[i].exp_valid) begin
                chk($sformatf("row%0d if_pc", i), if_id_pc_o, tbl[i].exp_pc);
                chk($sformatf("row%0d instr", i), if_id_instr_o, tbl[i].exp_instr);
            end
            chk($sformatf("row%0d bubble", i), {28'b0, bubble_cnt_o}, {28'b0, tbl[i].exp_bub});
            @(negedge clk_i);
        end
        stall_i = 1'b0; flush_i = 1'b0; redirect_pc_i = 32'h0;

        // Async reset mid-stall with the skid full (fetch of pc 0 in flight).
        stall_i = 1'b1;
        @(posedge clk_i); #3;
        rst_i = 1'b1;
        #1;
        chk("async valid",  {31'b0, if_id_valid_o}, 32'h0);
        chk("async bubble", {28'b0, bubble_cnt_o},  32'h0);
        chk("async en_n",   {31'b0, pc_enable_no},  32'h1);
        chk("async rd",     {31'b0, imem_rd_o},     32'h0);
        @(negedge clk_i);
        stall_i = 1'b0; rst_i = 1'b0;
        #1;
        chk("post-rst next_pc", next_pc_o, 32'h4);
        chk("post-rst en_n",    {31'b0, pc_enable_no}, 32'h0);
        @(posedge clk_i); #1;
        chk("post-rst valid0",  {31'b0, if_id_valid_o}, 32'h0);
        chk("post-rst bubble",  {28'b0, bubble_cnt_o},  32'h1);
        @(posedge clk_i); #1;
        chk("post-rst valid1",  {31'b0, if_id_valid_o}, 32'h1);
        chk("post-rst if_pc",   if_id_pc_o,             32'h0);
        chk("post-rst instr",   if_id_instr_o,          32'h10000000);

        // Bubble counter saturation: 20 flush edges into a 4-bit counter.
        @(negedge clk_i);
        flush_i = 1'b1; redirect_pc_i = 32'h0;
        repeat (20) @(posedge clk_i);
        #1;
        chk("sat flush", {28'b0, bubble_cnt_o}, 32'hF);
        @(negedge clk_i);
        flush_i = 1'b0;
        @(posedge clk_i); #1;
        chk("sat hold", {28'b0, bubble_cnt_o}, 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage between the PC register and decode in the non-forwarding pipeline.
- Computes the next PC and drives the PC register's active-low enable. Issues addresses to a synchronous-read instruction memory.
- Re-aligns the 1-cycle-late memory data with its PC through a one-entry skid buffer, and owns the IF/ID pipeline register with stall, flush and bubble insertion.

Parameters:
- WIDTH, 32, address/PC width
- INSTR_W, 32, instruction width
- CNT_W, 16, width of bubble performance counter

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- pc_i  in  WIDTH  current PC from PC register
- next_pc_o  out  WIDTH  next PC to PC register
- pc_enable_no  out  1  active-low PC update enable; 0 = PC loads next_pc_o
- imem_addr_o  out  WIDTH  instruction memory address
- imem_rd_o  out  1  read strobe, 1 when a fetch is issued
- imem_rdata_i  in  INSTR_W  memory data for the address sampled at the previous edge
- stall_i  in  1  hazard-unit stall; hold PC and IF/ID
- flush_i  in  1  taken branch/jump redirect from EX
- redirect_pc_i  in  WIDTH  redirect target
- if_id_valid_o  out  1  IF/ID holds a valid instruction
- if_id_pc_o  out  WIDTH  PC of IF/ID instruction
- if_id_instr_o  out  INSTR_W  IF/ID instruction
- bubble_cnt_o  out  CNT_W  count of bubbles inserted into IF/ID

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values:
  - if_id_valid_o = 0; if_id_pc_o = 0; if_id_instr_o = 0 (NOP not required).
  - Skid buffer empty; inflight_valid = 0; bubble_cnt_o = 0.
  - While rst_i is high, pc_enable_no = 1 and imem_rd_o = 0.
- Internal state:
  - inflight_valid/inflight_pc: a fetch was issued at the last edge.
  - skid_valid/skid_pc/skid_instr: holds the response captured during a stall.
- issue = !rst_i && !stall_i && !flush_i. imem_addr_o = pc_i always; imem_rd_o = issue.
- next_pc_o:
  - redirect_pc_i with bits[1:0] forced to 0 if flush_i.
  - Otherwise pc_i + 4, with modulo 2^WIDTH wrap (0xFFFFFFFC -> 0).
- pc_enable_no = 0 when flush_i or issue; otherwise 1.
- Priority: flush_i > stall_i > normal.
- Flush:
  - if_id_valid <= 0, skid_valid <= 0, inflight_valid <= 0; the response arriving this cycle is discarded.
  - Counts as a bubble.
  - Target instruction appears in IF/ID 2 edges after the flush edge (1 dead cycle).
- Stall (no flush):
  - IF/ID holds all fields.
  - If inflight_valid: skid <= {inflight_pc, imem_rdata_i}, skid_valid <= 1.
  - inflight_valid <= 0. Not counted as a bubble.
- Normal (no stall, no flush):
  - IF/ID loads from the skid if skid_valid (skid_valid <= 0).
  - Else it loads {inflight_pc, imem_rdata_i} if inflight_valid.
  - Else it loads a bubble: valid 0, pc/instr hold. A bubble increments bubble_cnt.
  - inflight_valid <= 1, inflight_pc <= pc_i.
- Invariant: skid_valid and inflight_valid are never both 1; a depth-1 skid suffices. Assert it.
- Latency: an instruction fetched at edge N is in IF/ID after edge N+1 with no stall.
- bubble_cnt_o saturates at 2^CNT_W-1.
- Asynchronous reset mid-stall or mid-flush clears all state immediately. No glitch on the valid output after release.

Test Plan:
- Reset release with pc 0 and memory word i = 0x1000_0000+i, no stall:
  - next_pc_o steps 4, 8, 12.
  - IF/ID shows (0, 0x10000000) then (4, 0x10000001) on consecutive cycles.
  - bubble_cnt_o = 1 (first cycle only).
- 3-cycle stall_i while PC = 0x10, with fetch 0x0C in flight:
  - pc_enable_no = 1 for 3 cycles; IF/ID holds 0x08.
  - On release IF/ID gets 0x0C from the skid, then 0x10. No lost or duplicated instruction.
- flush_i with redirect_pc_i = 0x103 at PC = 0x20:
  - next_pc_o = 0x100; IF/ID valid 0 for 2 cycles, then (0x100, mem[0x40]).
  - bubble_cnt_o += 2.
- flush_i and stall_i asserted together: flush wins. PC loads the target, skid cleared, IF/ID valid = 0.
- Wrap: pc_i = 0xFFFFFFFC, no stall -> next_pc_o = 0x00000000.
- rst_i asserted asynchronously mid-stall with skid full:
  - All valids 0 immediately without a clock edge.
  - After release, normal fetch from pc_i resumes.
